// File: rtl/stack_mc_pkg.sv
// Shared encodings for the stack multicycle controller: FSM states,
// opcode values, ALU operation codes and trap error codes.
package stack_mc_pkg;

    typedef enum logic [4:0] {
        FETCH,
        DECODE,
        MEMRD,
        PUSHMEM,
        POPA,
        LOADA,
        MEMWR,
        ALUNOT,
        POPB,
        LOADB,
        ALUBIN,
        PUSHRES,
        JUMP,
        BRANCH,
        DUPPUSH,
        HALT,
        TRAP
    } state_t;

    // Opcode values; anything above OP_HALT is illegal
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_PUSH = 4'd4;
    localparam logic [3:0] OP_POP  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_JZ   = 4'd7;
    localparam logic [3:0] OP_DUP  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_NOT = 2'd3;

    // Trap cause
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

endpackage

// File: rtl/stack_depth_cnt.sv
// Stack occupancy counter. Pushes and pops never coincide in the
// controller; the full/empty guards only keep the count from wrapping.
module stack_depth_cnt #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = $clog2(DEPTH + 1);

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    // Occupancy register: +1 on push, -1 on pop, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            depth <= '0;
        else if (inc && !dec && !full)
            depth <= depth + DW'(1);
        else if (dec && !inc && !empty)
            depth <= depth - DW'(1);
    end

endmodule

// File: rtl/stack_mc_controller.sv
// Moore-style multicycle controller for a stack machine. Every strobe is
// decoded from the current state; only the FETCH IR/PC load strobes are
// gated by mem_ready. Operand checks in DECODE route bad instructions to
// an absorbing TRAP state that records the cause.
module stack_mc_controller
    import stack_mc_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OPW-1:0]               opcode,
    input  logic                         mem_ready,
    output logic                         IorD,
    output logic                         srcA,
    output logic                         srcB,
    output logic                         lda,
    output logic                         ldb,
    output logic                         PCsrc,
    output logic                         PCwrite,
    output logic                         memRead,
    output logic                         IRwrite,
    output logic                         tos,
    output logic                         pop,
    output logic                         push,
    output logic                         MtoS,
    output logic                         PCwriteCond,
    output logic                         memWrite,
    output logic [1:0]                   ALUop,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         halted,
    output logic                         trap,
    output logic [1:0]                   err_code
);

    localparam int DW = $clog2(DEPTH + 1);

    state_t     state, next_state;
    logic [1:0] err_d;
    logic       err_set;
    logic       full, empty;
    logic       illegal;
    logic [3:0] op;

    // Opcodes above HALT are illegal; the low nibble is the decode key
    assign illegal = (opcode > OPW'(OP_HALT));
    assign op      = opcode[3:0];

    stack_depth_cnt #(.DEPTH(DEPTH)) u_depth (
        .clk   (clk),
        .rst   (rst),
        .inc   (push),
        .dec   (pop),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // State register; reset drops any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= next_state;
    end

    // Trap cause, latched on entry to TRAP and held until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_code <= ERR_NONE;
        else if (err_set)
            err_code <= err_d;
    end

    // Next-state selection and per-state output decode
    always_comb begin
        next_state  = state;
        err_d       = ERR_NONE;
        err_set     = 1'b0;
        IorD        = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        lda         = 1'b0;
        ldb         = 1'b0;
        PCsrc       = 1'b0;
        PCwrite     = 1'b0;
        memRead     = 1'b0;
        IRwrite     = 1'b0;
        tos         = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        MtoS        = 1'b0;
        PCwriteCond = 1'b0;
        memWrite    = 1'b0;
        ALUop       = ALU_ADD;
        halted      = 1'b0;
        trap        = 1'b0;

        unique case (state)
            FETCH: begin
                memRead = 1'b1;
                IRwrite = mem_ready;
                PCwrite = mem_ready;
                if (mem_ready)
                    next_state = DECODE;
            end

            DECODE: begin
                tos = 1'b1;
                if (illegal) begin
                    next_state = TRAP;
                    err_d      = ERR_ILLEGAL;
                    err_set    = 1'b1;
                end else if ((op <= OP_AND && depth < DW'(2)) ||
                             ((op == OP_NOT || op == OP_POP ||
                               op == OP_JZ  || op == OP_DUP) && empty)) begin
                    next_state = TRAP;
                    err_d      = ERR_UNDER;
                    err_set    = 1'b1;
                end else if ((op == OP_PUSH || op == OP_DUP) && full) begin
                    next_state = TRAP;
                    err_d      = ERR_OVER;
                    err_set    = 1'b1;
                end else begin
                    case (op)
                        OP_PUSH: next_state = MEMRD;
                        OP_JMP:  next_state = JUMP;
                        OP_JZ:   next_state = BRANCH;
                        OP_DUP:  next_state = DUPPUSH;
                        OP_HALT: next_state = HALT;
                        default: next_state = POPA;   // ADD/SUB/AND/NOT/POP
                    endcase
                end
            end

            MEMRD: begin
                IorD    = 1'b1;
                memRead = 1'b1;
                if (mem_ready)
                    next_state = PUSHMEM;
            end

            PUSHMEM: begin
                MtoS       = 1'b1;
                push       = 1'b1;
                next_state = FETCH;
            end

            POPA: begin
                pop        = 1'b1;
                next_state = LOADA;
            end

            LOADA: begin
                lda = 1'b1;
                if (op == OP_NOT)
                    next_state = ALUNOT;
                else if (op == OP_POP)
                    next_state = MEMWR;
                else
                    next_state = POPB;
            end

            MEMWR: begin
                IorD     = 1'b1;
                memWrite = 1'b1;
                if (mem_ready)
                    next_state = FETCH;
            end

            ALUNOT: begin
                srcA       = 1'b1;
                ALUop      = ALU_NOT;
                next_state = PUSHRES;
            end

            POPB: begin
                pop        = 1'b1;
                next_state = LOADB;
            end

            LOADB: begin
                ldb        = 1'b1;
                next_state = ALUBIN;
            end

            ALUBIN: begin
                srcA       = 1'b1;
                srcB       = 1'b1;
                ALUop      = opcode[1:0];
                next_state = PUSHRES;
            end

            PUSHRES: begin
                push       = 1'b1;
                next_state = FETCH;
            end

            JUMP: begin
                PCsrc      = 1'b1;
                PCwrite    = 1'b1;
                next_state = FETCH;
            end

            BRANCH: begin
                PCsrc       = 1'b1;
                PCwriteCond = 1'b1;
                next_state  = FETCH;
            end

            DUPPUSH: begin
                tos        = 1'b1;
                push       = 1'b1;
                next_state = FETCH;
            end

            HALT: begin
                halted = 1'b1;
            end

            TRAP: begin
                trap = 1'b1;
            end

            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_stack_mc_controller.sv
// Randomized and directed checks of the stack controller against an
// instruction-level reference: each opcode expands into its list of
// micro-steps, and the expected strobes, occupancy and trap cause follow.
module tb_stack_mc_controller;

    localparam int OPW   = 4;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic           clk, rst;
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite;
    logic tos, pop, push, MtoS, PCwriteCond, memWrite;
    logic [1:0]     ALUop;
    logic [DW-1:0]  depth;
    logic           halted, trap;
    logic [1:0]     err_code;

    typedef enum {
        P_FETCH, P_DECODE, P_MEMRD, P_PUSHMEM, P_POPA, P_LOADA, P_MEMWR,
        P_ALUNOT, P_POPB, P_LOADB, P_ALUBIN, P_PUSHRES, P_JUMP, P_BRANCH,
        P_DUPPUSH, P_HALT, P_TRAP
    } phase_e;

    typedef struct packed {
        logic iord, lda, ldb, pcsrc, pcwrite, memread, irwrite, tos;
        logic pop, push, mtos, pcwc, memwrite;
    } strb_t;

    strb_t obs;
    assign obs = {IorD, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos,
                  pop, push, MtoS, PCwriteCond, memWrite};

    int n_assert = 0;
    int n_fail   = 0;
    int mdepth, merr, cur_op, cyc;
    int n_push_seen, n_pop_seen, n_memrd_seen;
    bit terminal;

    stack_mc_controller #(.OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .srcA(srcA), .srcB(srcB), .lda(lda), .ldb(ldb),
        .PCsrc(PCsrc), .PCwrite(PCwrite), .memRead(memRead),
        .IRwrite(IRwrite), .tos(tos), .pop(pop), .push(push), .MtoS(MtoS),
        .PCwriteCond(PCwriteCond), .memWrite(memWrite), .ALUop(ALUop),
        .depth(depth), .halted(halted), .trap(trap), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Strobes each micro-step is defined to raise
    function automatic strb_t exp_strb(input phase_e p, input logic rdy);
        strb_t s = '0;
        case (p)
            P_FETCH:   begin s.memread = 1; s.irwrite = rdy; s.pcwrite = rdy; end
            P_DECODE:  s.tos = 1;
            P_MEMRD:   begin s.iord = 1; s.memread = 1; end
            P_PUSHMEM: begin s.mtos = 1; s.push = 1; end
            P_POPA:    s.pop = 1;
            P_POPB:    s.pop = 1;
            P_LOADA:   s.lda = 1;
            P_LOADB:   s.ldb = 1;
            P_MEMWR:   begin s.iord = 1; s.memwrite = 1; end
            P_PUSHRES: s.push = 1;
            P_JUMP:    begin s.pcsrc = 1; s.pcwrite = 1; end
            P_BRANCH:  begin s.pcsrc = 1; s.pcwc = 1; end
            P_DUPPUSH: begin s.tos = 1; s.push = 1; end
            default:   s = '0;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One clock of a micro-step: drive mem_ready, check at the falling
    // edge, then advance the reference occupancy past the rising edge.
    task automatic step(input phase_e p, input logic rdy);
        strb_t e;
        e = exp_strb(p, rdy);
        mem_ready = rdy;
        @(negedge clk);
        chk($sformatf("strobes@%s", p.name()), 32'(obs), 32'(e));
        if (p == P_ALUBIN)
            chk("aluop_bin", 32'(ALUop), 32'(cur_op % 4));
        else if (p == P_ALUNOT)
            chk("aluop_not", 32'(ALUop), 32'd3);
        else if (p == P_HALT || p == P_TRAP)
            chk("aluop_idle", 32'(ALUop), 32'd0);
        chk("depth", 32'(depth), 32'(mdepth));
        chk("halted", 32'(halted), 32'(p == P_HALT));
        chk("trap", 32'(trap), 32'(p == P_TRAP));
        chk("err_code", 32'(err_code), 32'(merr));
        if (push) n_push_seen++;
        if (pop) n_pop_seen++;
        if (IorD && memRead) n_memrd_seen++;
        cyc++;
        @(posedge clk); #1;
        if (e.push) mdepth++;
        if (e.pop) mdepth--;
    endtask

    task automatic rnd_step(input phase_e p);
        step(p, 1'($urandom_range(0, 1)));
    endtask

    task automatic trap_to(input int code);
        merr = code;
        terminal = 1;
        repeat (3) rnd_step(P_TRAP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_strobes_r0", 32'(obs), 32'(exp_strb(P_FETCH, 1'b0)));
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes_r1", 32'(obs), 32'(exp_strb(P_FETCH, 1'b1)));
        chk("rst_srcab", 32'({srcA, srcB}), 32'd0);
        chk("rst_aluop", 32'(ALUop), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_flags", 32'({halted, trap}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdepth = 0;
        merr = 0;
        terminal = 0;
    endtask

    // Expand one instruction into its micro-steps. fw/mw are the numbers
    // of not-ready cycles spent in FETCH and in the data memory access.
    task automatic run_instr(input int op, input int fw, input int mw);
        cur_op = op;
        opcode = OPW'(op);
        repeat (fw) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        rnd_step(P_DECODE);
        if (op > 9)
            trap_to(3);
        else if ((op <= 2 && mdepth < 2) ||
                 ((op == 3 || op == 5 || op == 7 || op == 8) && mdepth < 1))
            trap_to(1);
        else if ((op == 4 || op == 8) && mdepth >= DEPTH)
            trap_to(2);
        else begin
            case (op)
                0, 1, 2: begin
                    rnd_step(P_POPA); rnd_step(P_LOADA); rnd_step(P_POPB);
                    rnd_step(P_LOADB); rnd_step(P_ALUBIN); rnd_step(P_PUSHRES);
                end
                3: begin
                    rnd_step(P_POPA); rnd_step(P_LOADA);
                    rnd_step(P_ALUNOT); rnd_step(P_PUSHRES);
                end
                4: begin
                    repeat (mw) step(P_MEMRD, 1'b0);
                    step(P_MEMRD, 1'b1);
                    rnd_step(P_PUSHMEM);
                end
                5: begin
                    rnd_step(P_POPA); rnd_step(P_LOADA);
                    repeat (mw) step(P_MEMWR, 1'b0);
                    step(P_MEMWR, 1'b1);
                end
                6: rnd_step(P_JUMP);
                7: rnd_step(P_BRANCH);
                8: rnd_step(P_DUPPUSH);
                default: begin
                    terminal = 1;
                    repeat (3) rnd_step(P_HALT);
                end
            endcase
        end
    endtask

    initial begin
        int c0, p0, m0, q0, op, r;
        rst = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;
        cyc = 0; n_push_seen = 0; n_pop_seen = 0; n_memrd_seen = 0;
        mdepth = 0; merr = 0; cur_op = 0; terminal = 0;
        @(posedge clk); #1;

        // PUSH, PUSH, ADD with memory always ready
        do_reset();
        run_instr(4, 0, 0);
        chk("depth_after_push1", 32'(depth), 32'd1);
        run_instr(4, 0, 0);
        chk("depth_after_push2", 32'(depth), 32'd2);
        c0 = cyc;
        run_instr(0, 0, 0);
        chk("depth_after_add", 32'(depth), 32'd1);
        chk("add_cycles", 32'(cyc - c0), 32'd8);
        step(P_FETCH, 1'b0);

        // PUSH with three wait cycles on the data read
        p0 = n_push_seen; m0 = n_memrd_seen;
        run_instr(4, 0, 3);
        chk("memrd_cycles", 32'(n_memrd_seen - m0), 32'd4);
        chk("push_count", 32'(n_push_seen - p0), 32'd1);

        // Binary op with a single operand traps on underflow
        do_reset();
        run_instr(4, 1, 0);
        q0 = n_pop_seen;
        run_instr(0, 0, 0);
        chk("underflow_err", 32'(err_code), 32'd1);
        chk("underflow_trap", 32'(trap), 32'd1);
        chk("underflow_no_pop", 32'(n_pop_seen - q0), 32'd0);

        // Fill the stack then DUP: overflow
        do_reset();
        repeat (DEPTH) run_instr(4, 0, 0);
        run_instr(8, 0, 0);
        chk("overflow_err", 32'(err_code), 32'd2);
        chk("overflow_depth", 32'(depth), 32'(DEPTH));

        // Illegal opcode, then HALT held for ten cycles
        do_reset();
        run_instr(15, 0, 0);
        chk("illegal_err", 32'(err_code), 32'd3);
        do_reset();
        run_instr(9, 0, 0);
        repeat (7) rnd_step(P_HALT);
        chk("halted_held", 32'(halted), 32'd1);

        // Reset while POP waits in MEMWR
        do_reset();
        run_instr(4, 0, 0);
        cur_op = 5;
        opcode = OPW'(5);
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        step(P_POPA, 1'b0);
        step(P_LOADA, 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("memwr_before_rst", 32'(memWrite), 32'd1);
        rst = 1'b1;
        #1;
        chk("memwr_async_drop", 32'(memWrite), 32'd0);
        chk("rst_in_fetch", 32'(memRead), 32'd1);
        chk("rst_depth_clear", 32'(depth), 32'd0);
        @(posedge clk); #1;
        chk("rst_held_strobes", 32'(obs), 32'(exp_strb(P_FETCH, 1'b0)));
        rst = 1'b0;
        mdepth = 0; merr = 0; terminal = 0;

        // Random instruction mix
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (terminal) do_reset();
            r = $urandom_range(0, 99);
            if (r < 30)      op = 4;
            else if (r < 90) op = $urandom_range(0, 8);
            else             op = $urandom_range(9, 15);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
